// File: rtl/btn_press_conditioner.sv
// Four-button front end: 2-flop synchronizer, per-bit debounce counter, and a
// single-entry press event register with ready/valid handoff.
module btn_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       press_ready,
  output logic [3:0] btn_level,
  output logic       press_valid,
  output logic [1:0] press_idx,
  output logic [3:0] press_onehot,
  output logic       multi_press,
  output logic       overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    level_q, level_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    flip;
  logic [3:0]    rise;
  logic [1:0]    low_idx;
  logic          multi_any;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          multi_q, multi_d;
  logic          overrun_q, overrun_d;

  // A bit flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      assign flip[gi]  = (sync2_q[gi] != level_q[gi]) && (cnt_q[gi] == CNT_LAST);
      assign cnt_d[gi] = ((sync2_q[gi] == level_q[gi]) || flip[gi]) ? '0
                                                                     : cnt_q[gi] + CW'(1);
    end
  endgenerate

  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    level_d   = level_q ^ flip;
    rise      = flip & ~level_q;
    multi_any = (rise & (rise - 4'd1)) != 4'd0;
    low_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    multi_d   = multi_any;
    overrun_d = 1'b0;
    case (state_q)
      EMPTY: begin
        if (|rise) begin
          state_d = PENDING;
          idx_d   = low_idx;
        end
      end
      PENDING: begin
        if (press_ready) begin
          // Accept the old event; a same-edge rise replaces it directly.
          if (|rise) idx_d = low_idx;
          else       state_d = EMPTY;
        end else if (|rise) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q   <= EMPTY;
      idx_q     <= '0;
      multi_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      idx_q     <= idx_d;
      multi_q   <= multi_d;
      overrun_q <= overrun_d;
    end
  end

  assign btn_level    = level_q;
  assign press_valid  = (state_q == PENDING);
  assign press_idx    = idx_q;
  assign press_onehot = (state_q == PENDING) ? (4'b0001 << idx_q) : 4'b0000;
  assign multi_press  = multi_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/btn_press_conditioner.md
BTN_PRESS_CONDITIONER -- requirements
Module: btn_press_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: the number of consecutive cycles a synchronized button value must differ from its debounced level before that level changes (legal range 2..65535).
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 Port btn  input  4  carries the raw, asynchronous, bouncing buttons (bit i = button i).
REQ-005 Port press_ready  input  1  is high when the downstream game logic accepts a press event.
REQ-006 Port btn_level  output  4  is the debounced level of each button.
REQ-007 Port press_valid  output  1  is high while a press event is pending.
REQ-008 Port press_idx  output  2  is the index of the pending press.
REQ-009 Port press_onehot  output  4  is the one-hot form of press_idx, and SHALL be 4'b0000 when press_valid is 0.
REQ-010 Port multi_press  output  1  is a 1-cycle pulse flagging that more than one button rose in the same cycle.
REQ-011 Port overrun  output  1  is a 1-cycle pulse flagging that a press was dropped because an event was already pending.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-013 Each bit SHALL own a debounce counter of width ceil(log2(DEBOUNCE_CYCLES+1)) with the following behaviour:
- sync2 == btn_level: the counter clears to 0.
- sync2 != btn_level and the counter is below DEBOUNCE_CYCLES-1: the counter increments.
- sync2 != btn_level and the counter equals DEBOUNCE_CYCLES-1: btn_level toggles and the counter clears.
REQ-014 Timing of a level change: if raw btn[i] changes before edge 1 and stays stable, btn_level[i] SHALL change at edge DEBOUNCE_CYCLES+2.
REQ-015 A glitch on sync2 shorter than DEBOUNCE_CYCLES cycles SHALL clear the counter and SHALL leave btn_level unchanged.
REQ-016 A "rise" on bit i SHALL be the edge at which btn_level[i] toggles 0->1; 1->0 transitions SHALL generate no event.
REQ-017 Press event register states: EMPTY (press_valid=0) and PENDING (press_valid=1).
REQ-018 EMPTY, any rise at an edge: go to PENDING at that same edge, with press_idx = lowest rising index.
- press_valid therefore rises together with btn_level, giving a total latency of DEBOUNCE_CYCLES+2 cycles.
REQ-019 PENDING, press_ready=1 at an edge, no rise: the event is accepted and the state goes to EMPTY.
REQ-020 PENDING, press_ready=1 at an edge, with a rise at the same edge: the old event is accepted and the new one loads, so press_valid stays 1 and press_idx takes the new index.
REQ-021 PENDING, press_ready=0 at an edge, with a rise at the same edge: the new rise is dropped, press_idx is held, and overrun pulses high for exactly 1 cycle.
REQ-022 press_idx and press_onehot SHALL remain stable while press_valid=1 and press_ready=0.
REQ-023 Two or more rises at the same edge SHALL pulse multi_press for 1 cycle.
- This holds whether the lowest index is loaded or dropped.
- The non-selected rises SHALL be discarded without asserting overrun.
REQ-024 press_ready sampled while press_valid=0 SHALL have no effect.
REQ-025 overrun and multi_press SHALL be registered outputs with no combinational path from any input.

Reset
REQ-026 While rst=0, the following SHALL be 0 asynchronously, independent of clk:
- sync flops and debounce counters;
- btn_level, press_valid, press_idx, press_onehot, multi_press, overrun.
REQ-027 Reset asserted mid-debounce or with an event pending SHALL discard all in-progress state; no event SHALL be emitted for buttons that were pending at the time of reset.
REQ-028 After rst deasserts, a button already held high SHALL be treated as a fresh rise after DEBOUNCE_CYCLES+2 cycles.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Clean press: btn=4'b0100 held from cycle 0 -> btn_level=4'b0100 and press_valid=1 with press_idx=2 and press_onehot=4'b0100 at edge 6; press_ready=1 at edge 8 -> press_valid=0 after edge 8.
REQ-030 Bounce: btn[0] toggles 1,0,1,0 on successive cycles, then holds 1 -> no change to btn_level until 4 consecutive stable sync2 cycles, then exactly one event with press_idx=0.
REQ-031 Simultaneous press: btn 0000->1010 in one cycle -> press_idx=1 and multi_press pulses 1 cycle at edge 6; overrun stays 0.
REQ-032 Overrun: event idx=0 pending with press_ready=0, then btn[3] rises -> overrun pulses once and press_idx stays 0; press_ready=1 -> press_valid=0, and no idx=3 event appears.
REQ-033 Accept plus new rise at the same edge: press_ready=1 exactly at the edge where btn[2] becomes stable -> press_valid remains 1 with press_idx=2.
REQ-034 Reset mid-operation: rst=0 for 1 cycle, asynchronously, while an event is pending and btn=4'b0001 is held -> all outputs 0 immediately; after release, a new event with press_idx=0 appears 6 edges later.
